// File: rtl/timed_flag_match_if.sv
// Read-only burst databus between the flag matcher (master) and the memory system (slave).
// Write channels are kept so the bus shape matches the other accelerator units.
interface timed_flag_match_if #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = 8
);
    logic                    databus_ready_0;
    logic                    databus_valid_0;
    logic [AXI_ADDR_W-1:0]   databus_addr_0;
    logic [AXI_DATA_W-1:0]   databus_rdata_0;
    logic [AXI_DATA_W-1:0]   databus_wdata_0;
    logic [AXI_DATA_W/8-1:0] databus_wstrb_0;
    logic [LEN_W-1:0]        databus_len_0;
    logic                    databus_last_0;

    modport master (
        input  databus_ready_0, databus_rdata_0, databus_last_0,
        output databus_valid_0, databus_addr_0, databus_wdata_0, databus_wstrb_0, databus_len_0
    );

    modport slave (
        output databus_ready_0, databus_rdata_0, databus_last_0,
        input  databus_valid_0, databus_addr_0, databus_wdata_0, databus_wstrb_0, databus_len_0
    );
endinterface

// File: rtl/timed_flag_match.sv
// Ping-pong flag matcher: bursts flag words into one memory bank while scanning the
// other bank against the in0 stream, with compare modes, start delay and watchdog.
module timed_flag_match #(
    parameter int FLAG_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  running,
    input  logic                  run,
    output logic                  done,

    timed_flag_match_if.master    databus,

    output logic [ADDR_W-1:0]     ext_dp_addr_0_port_0,
    output logic [FLAG_W-1:0]     ext_dp_out_0_port_0,
    input  logic [FLAG_W-1:0]     ext_dp_in_0_port_0,
    output logic                  ext_dp_enable_0_port_0,
    output logic                  ext_dp_write_0_port_0,
    output logic [ADDR_W-1:0]     ext_dp_addr_0_port_1,
    output logic [AXI_DATA_W-1:0] ext_dp_out_0_port_1,
    input  logic [AXI_DATA_W-1:0] ext_dp_in_0_port_1,
    output logic                  ext_dp_enable_0_port_1,
    output logic                  ext_dp_write_0_port_1,

    input  logic [AXI_ADDR_W-1:0] ext_addr,
    input  logic [LEN_W-1:0]      length,
    input  logic [1:0]            mode,
    input  logic [FLAG_W-1:0]     mask,
    input  logic [CNT_W-1:0]      timeout,
    input  logic                  disabled,
    input  logic [31:0]           delay0,

    input  logic [31:0]           in0,
    output logic [31:0]           out0,
    output logic [31:0]           out1
);
    localparam int IDX_W = ADDR_W - 1;

    logic                  bank_q, bank_d;
    logic [31:0]           delay_q, delay_d;
    logic [CNT_W-1:0]      need_q, need_d;
    logic [IDX_W-1:0]      fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0]      fetched_q, fetched_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]      matches_q, matches_d;
    logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  timed_out_q, timed_out_d;
    logic                  fill_active_q, fill_active_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]           out0_q, out0_d;

    logic [FLAG_W-1:0]     a_val;
    logic [FLAG_W-1:0]     b_val;
    logic                  hit;
    logic                  active;
    logic                  adv;
    logic                  beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_q        <= 1'b0;
            delay_q       <= '0;
            need_q        <= '0;
            fill_cnt_q    <= '0;
            fetched_q     <= '0;
            rd_idx_q      <= '0;
            matches_q     <= '0;
            tmo_cnt_q     <= '0;
            timed_out_q   <= 1'b0;
            fill_active_q <= 1'b0;
            addr_q        <= '0;
            out0_q        <= '0;
        end else begin
            bank_q        <= bank_d;
            delay_q       <= delay_d;
            need_q        <= need_d;
            fill_cnt_q    <= fill_cnt_d;
            fetched_q     <= fetched_d;
            rd_idx_q      <= rd_idx_d;
            matches_q     <= matches_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timed_out_q   <= timed_out_d;
            fill_active_q <= fill_active_d;
            addr_q        <= addr_d;
            out0_q        <= out0_d;
        end
    end

    always_comb begin
        a_val = in0[FLAG_W-1:0];
        b_val = ext_dp_in_0_port_0;
        case (mode)
            2'd1:    hit = (a_val >= b_val);
            2'd2:    hit = ((a_val ^ b_val) & mask) == '0;
            default: hit = (a_val == b_val);
        endcase
        active = (delay_q == '0) && !disabled && (need_q != '0) && !timed_out_q;
        adv    = active && hit;
        beat   = fill_active_q && databus.databus_ready_0;
    end

    always_comb begin
        bank_d        = bank_q;
        delay_d       = delay_q;
        need_d        = need_q;
        fill_cnt_d    = fill_cnt_q;
        fetched_d     = fetched_q;
        rd_idx_d      = rd_idx_q;
        matches_d     = matches_q;
        tmo_cnt_d     = tmo_cnt_q;
        timed_out_d   = timed_out_q;
        fill_active_d = fill_active_q;
        addr_d        = addr_q;
        out0_d        = '0;
        if (run) begin
            bank_d        = !bank_q;
            addr_d        = ext_addr;
            fill_active_d = 1'b1;
            fill_cnt_d    = '0;
            need_d        = fetched_q;
            fetched_d     = '0;
            delay_d       = delay0;
            rd_idx_d      = '0;
            matches_d     = '0;
            tmo_cnt_d     = '0;
            timed_out_d   = 1'b0;
        end else begin
            if (beat) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
                fetched_d  = fetched_q + 1'b1;
                if (databus.databus_last_0)
                    fill_active_d = 1'b0;
            end
            if (delay_q != '0) begin
                delay_d = delay_q - 1'b1;
            end else if (adv) begin
                rd_idx_d  = rd_idx_q + 1'b1;
                need_d    = need_q - 1'b1;
                matches_d = matches_q + 1'b1;
                tmo_cnt_d = '0;
                out0_d    = '1;
            end else if (active) begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if ((timeout != '0) && (tmo_cnt_q == timeout - 1'b1))
                    timed_out_d = 1'b1;
            end
        end
    end

    // The scan address is taken from next-state values so the registered memory
    // read already holds entry rd_idx of the new scan bank on the cycle after run.
    always_comb begin
        ext_dp_addr_0_port_0   = {!bank_d, rd_idx_d};
        ext_dp_out_0_port_0    = '0;
        ext_dp_enable_0_port_0 = running;
        ext_dp_write_0_port_0  = 1'b0;

        ext_dp_addr_0_port_1   = {bank_q, fill_cnt_q};
        ext_dp_out_0_port_1    = databus.databus_rdata_0;
        ext_dp_enable_0_port_1 = beat;
        ext_dp_write_0_port_1  = 1'b1;

        databus.databus_valid_0 = fill_active_q;
        databus.databus_addr_0  = addr_q;
        databus.databus_wdata_0 = '0;
        databus.databus_wstrb_0 = '0;
        databus.databus_len_0   = length;

        out0 = out0_q;
        out1 = {timed_out_q, {(31-CNT_W){1'b0}}, matches_q};
        done = !running || disabled || ((need_q == '0 || timed_out_q) && !fill_active_q);
    end

    logic unused_inputs;
    assign unused_inputs = ^{1'b0, ext_dp_in_0_port_1, in0};

endmodule

// File: tb/tb_timed_flag_match.sv
// Directed bench for timed_flag_match: bus slave and ping-pong memory model plus
// a linear sequence of runs with hand-computed expectations.
module tb_timed_flag_match;
    localparam int FLAG_W = 16;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    logic running, run, done;
    logic [ADDR_W-1:0] a0, a1;
    logic [FLAG_W-1:0] o0, rd0;
    logic [31:0]       o1;
    logic en0, wr0, en1, wr1;
    logic [31:0] ext_addr;
    logic [7:0]  length;
    logic [1:0]  mode;
    logic [FLAG_W-1:0] mask;
    logic [CNT_W-1:0]  timeout;
    logic disabled;
    logic [31:0] delay0, in0, out0, out1;

    logic [FLAG_W-1:0] mem [0:255];
    logic [31:0] burst [0:7];
    int nbeats = 0;
    int beat = 0;
    int checks = 0;
    int errors = 0;

    timed_flag_match_if bus ();

    timed_flag_match #(.FLAG_W(FLAG_W), .ADDR_W(ADDR_W), .AXI_ADDR_W(32), .AXI_DATA_W(32),
                       .LEN_W(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .running(running), .run(run), .done(done),
        .databus(bus.master),
        .ext_dp_addr_0_port_0(a0), .ext_dp_out_0_port_0(o0), .ext_dp_in_0_port_0(rd0),
        .ext_dp_enable_0_port_0(en0), .ext_dp_write_0_port_0(wr0),
        .ext_dp_addr_0_port_1(a1), .ext_dp_out_0_port_1(o1), .ext_dp_in_0_port_1(32'd0),
        .ext_dp_enable_0_port_1(en1), .ext_dp_write_0_port_1(wr1),
        .ext_addr(ext_addr), .length(length), .mode(mode), .mask(mask), .timeout(timeout),
        .disabled(disabled), .delay0(delay0), .in0(in0), .out0(out0), .out1(out1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en1 && wr1) mem[a1] <= o1[FLAG_W-1:0];
        if (en0) rd0 <= mem[a0];
    end

    always @(posedge clk) begin
        if (run) beat <= 0;
        else if (bus.databus_valid_0 && bus.databus_ready_0) beat <= beat + 1;
    end

    initial begin
        bus.databus_ready_0 = 1'b0;
        bus.databus_rdata_0 = '0;
        bus.databus_last_0  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.databus_valid_0) begin
                bus.databus_ready_0 = 1'b1;
                bus.databus_rdata_0 = burst[beat & 7];
                bus.databus_last_0  = (beat == nbeats - 1);
            end else begin
                bus.databus_ready_0 = 1'b0;
                bus.databus_last_0  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int id, input logic [7:0] len, input logic [31:0] base);
        length   = len;
        nbeats   = int'(len);
        ext_addr = base;
        run      = 1'b1;
        $display("run %0d: mode=%0d delay0=%0d timeout=%0d disabled=%0d len=%0d",
                 id, mode, delay0, timeout, disabled, len);
        tick();
        run = 1'b0;
    endtask

    initial begin
        rst = 1'b0; running = 1'b0; run = 1'b0;
        ext_addr = '0; length = '0; mode = '0; mask = '0; timeout = '0;
        disabled = 1'b0; delay0 = '0; in0 = '0;
        for (int i = 0; i < 8; i++) burst[i] = '0;
        tick(); tick();
        chk("rst_valid", {31'd0, bus.databus_valid_0}, 32'd0);
        chk("rst_out0", out0, 32'd0);
        chk("rst_out1", out1, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd1);
        rst = 1'b1;
        running = 1'b1;
        tick();

        // reset during the second beat of a fill
        burst[0] = 32'd1; burst[1] = 32'd2; burst[2] = 32'd3;
        start_run(0, 8'd3, 32'h100);
        chk("fill_valid", {31'd0, bus.databus_valid_0}, 32'd1);
        chk("fill_addr", bus.databus_addr_0, 32'h100);
        chk("fill_len", {24'd0, bus.databus_len_0}, 32'd3);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_valid", {31'd0, bus.databus_valid_0}, 32'd0);
        chk("midrst_addr", bus.databus_addr_0, 32'd0);
        chk("midrst_out0", out0, 32'd0);
        chk("midrst_out1", out1, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd1);
        rst = 1'b1;
        tick();

        // run 1: fill bank1 with 5,7,9, nothing to scan
        burst[0] = 32'd5; burst[1] = 32'd7; burst[2] = 32'd9;
        start_run(1, 8'd3, 32'h200);
        chk("r1_done_busy", {31'd0, done}, 32'd0);
        tick();
        chk("r1_done_mid", {31'd0, done}, 32'd0);
        tick(); tick();
        chk("r1_valid_end", {31'd0, bus.databus_valid_0}, 32'd0);
        chk("r1_done_end", {31'd0, done}, 32'd1);
        chk("r1_mem0", {16'd0, mem[128]}, 32'd5);
        chk("r1_mem1", {16'd0, mem[129]}, 32'd7);
        chk("r1_mem2", {16'd0, mem[130]}, 32'd9);

        // run 2: equal mode, delay 2, scan 5,7,9; fill bank0 with 4,4
        mode = 2'd0; delay0 = 32'd2; in0 = 32'd5;
        burst[0] = 32'd4; burst[1] = 32'd4;
        start_run(2, 8'd2, 32'h300);
        chk("r2_out0_e0", out0, 32'd0);
        tick();
        chk("r2_out0_dly1", out0, 32'd0);
        tick();
        chk("r2_out0_dly2", out0, 32'd0);
        tick();
        chk("r2_out0_m5", out0, ONES);
        in0 = 32'd7;
        tick();
        chk("r2_out0_m7", out0, ONES);
        in0 = 32'd9;
        tick();
        chk("r2_out0_m9", out0, ONES);
        chk("r2_out1", out1, 32'd3);
        chk("r2_done", {31'd0, done}, 32'd1);
        tick();
        chk("r2_out0_idle", out0, 32'd0);
        delay0 = 32'd0;

        // run 3: ge mode over 4,4; fill bank1 with 0x12AB
        mode = 2'd1; in0 = 32'd3;
        burst[0] = 32'h12AB;
        start_run(3, 8'd1, 32'h400);
        tick();
        chk("r3_ge_below", out0, 32'd0);
        in0 = 32'd10;
        tick();
        chk("r3_ge_1", out0, ONES);
        tick();
        chk("r3_ge_2", out0, ONES);
        chk("r3_out1", out1, 32'd2);
        chk("r3_done", {31'd0, done}, 32'd1);

        // run 4: masked mode on 0x12AB vs 0x34AB; fill bank0 with 8
        mode = 2'd2; mask = 16'hFFFF; in0 = 32'h34AB;
        burst[0] = 32'd8;
        start_run(4, 8'd1, 32'h500);
        tick();
        chk("r4_mask_full", out0, 32'd0);
        mask = 16'h00FF;
        tick();
        chk("r4_mask_low", out0, ONES);
        chk("r4_out1", out1, 32'd1);

        // run 5: watchdog of 4 on entry 8 with in0=1; fill bank1 with 1,2
        mode = 2'd0; timeout = 16'd4; in0 = 32'd1;
        burst[0] = 32'd1; burst[1] = 32'd2;
        start_run(5, 8'd2, 32'h600);
        tick(); tick();
        chk("r5_out0_a", out0, 32'd0);
        tick();
        chk("r5_out1_pre", out1, 32'd0);
        chk("r5_done_pre", {31'd0, done}, 32'd0);
        tick();
        chk("r5_out1_tmo", out1, 32'h8000_0000);
        chk("r5_done_tmo", {31'd0, done}, 32'd1);
        chk("r5_out0_b", out0, 32'd0);
        tick();
        chk("r5_out1_hold", out1, 32'h8000_0000);
        timeout = '0;

        // run 6: disabled with two entries pending; fill bank0 with 3,3,3
        disabled = 1'b1; in0 = 32'd1;
        burst[0] = 32'd3; burst[1] = 32'd3; burst[2] = 32'd3;
        start_run(6, 8'd3, 32'h700);
        chk("r6_done", {31'd0, done}, 32'd1);
        chk("r6_valid", {31'd0, bus.databus_valid_0}, 32'd1);
        tick();
        chk("r6_out0_a", out0, 32'd0);
        tick();
        chk("r6_out0_b", out0, 32'd0);
        tick();
        chk("r6_valid_end", {31'd0, bus.databus_valid_0}, 32'd0);
        chk("r6_out1", out1, 32'd0);
        chk("r6_mem2", {16'd0, mem[2]}, 32'd3);

        // run 7: enabled again; the three beats fetched while disabled are scanned
        disabled = 1'b0; mode = 2'd1; in0 = 32'h0000_FFFF;
        burst[0] = 32'd0;
        start_run(7, 8'd1, 32'h800);
        tick();
        chk("r7_m1", out0, ONES);
        tick();
        chk("r7_m2", out0, ONES);
        tick();
        chk("r7_m3", out0, ONES);
        chk("r7_out1", out1, 32'd3);
        chk("r7_done", {31'd0, done}, 32'd1);
        tick();
        chk("r7_idle", out0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
